mem_burst_ctrl: RTL

Burst sequencer for the memory driver. Accepts one command at a time (direction, base address, beat count) and steps an internal address counter to issue one single-port synchronous-memory access per cycle. Writes stream from a data source; reads return with a valid strobe. A `pause` input stalls the burst, and `done`/`err` pulses report completion.

---
 rtl/mem_burst_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: one command in, one synchronous-memory access per cycle out.
// Define MEM_BURST_WRAP_EN to let bursts wrap past the top of memory instead of rejecting them.
module mem_burst_ctrl #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_rw,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          pause,
    input  logic [DW-1:0] wr_data,
    output logic          wr_data_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StErr} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] beats_q, beats_d;
    logic          rw_q, rw_d;
    logic          accept, fire, last_beat, overflow;
    logic          rd_valid_q, done_q, err_q, busy_q, ready_q;
    logic [DW-1:0] rd_hold_q;

    assign accept    = cmd_valid && (state_q == StIdle);
    assign fire      = (state_q == StRun) && !pause;
    assign last_beat = fire && (beats_q == '0);

`ifdef MEM_BURST_WRAP_EN
    assign overflow = 1'b0;
`else
    localparam int unsigned SW = AW + LW;
    logic [SW-1:0] span;
    // Any bit above AW means the last beat would fall past the top address.
    assign span     = SW'(cmd_addr) + SW'(cmd_len);
    assign overflow = |span[SW-1:AW];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = overflow ? StErr : StRun;
            StRun:   if (last_beat) state_d = rw_q ? StDone : StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr    = addr_q;
        mem_we      = fire && rw_q;
        mem_re      = fire && !rw_q;
        wr_data_req = fire && rw_q;
        mem_wdata   = (fire && rw_q) ? wr_data : '0;
    end

    always_comb begin
        rw_d    = rw_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        if (accept) begin
            rw_d    = cmd_rw;
            addr_d  = cmd_addr;
            beats_d = cmd_len;
        end else if (fire) begin
            addr_d  = addr_q + AW'(1);
            beats_d = beats_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            rd_valid_q <= mem_re;
            if (rd_valid_q) begin
                rd_hold_q <= mem_rdata;
            end
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
            busy_q  <= (state_d != StIdle);
            ready_q <= (state_d == StIdle);
        end
    end

    // Memory returns data in the rd_valid cycle; pass it through then, hold it afterwards.
    assign rd_data   = rd_valid_q ? mem_rdata : rd_hold_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign cmd_ready = ready_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_we && mem_re));
    a_strobe_run:  assert property (@(posedge clk) disable iff (rst)
                                    (mem_we || mem_re) |-> (state_q == StRun));
    a_pulse_excl:  assert property (@(posedge clk) disable iff (rst) !(done && err));

endmodule
